// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with write-through
// forwarding, hardwired-zero x0, a pending-write scoreboard and a sequential
// clear engine that zeroes one entry per cycle after reset.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rs_addr/rs_valid     NUM_RD read ports (port i at [i*AW +: AW])
//   rs_data              combinational read data, NUM_RD*XLEN
//   rs_busy              per read port: source has a pending, unforwarded write
//   wr_en/wr_addr/wr_data NUM_WR write ports; highest index wins on collisions
//   iss_en/iss_rd        issue: mark iss_rd pending in the scoreboard
//   ready                registered; high once the clear engine has finished
//   par_err              per read port stored-parity mismatch
//
// Optional feature: define REGFILE_PARITY_EN to store an even-parity bit per
// entry and flag mismatches on storage reads; otherwise par_err is tied to 0.

module regfile_mp #(
   parameter  int unsigned XLEN   = 32,
   parameter  int unsigned NREGS  = 32,
   parameter  int unsigned NUM_RD = 2,
   parameter  int unsigned NUM_WR = 1,
   localparam int unsigned AW     = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   rs_addr,
   input  logic [NUM_RD-1:0]      rs_valid,
   output logic [NUM_RD*XLEN-1:0] rs_data,
   output logic [NUM_RD-1:0]      rs_busy,
   input  logic [NUM_WR-1:0]      wr_en,
   input  logic [NUM_WR*AW-1:0]   wr_addr,
   input  logic [NUM_WR*XLEN-1:0] wr_data,
   input  logic                   iss_en,
   input  logic [AW-1:0]          iss_rd,
   output logic                   ready,
   output logic [NUM_RD-1:0]      par_err
);

   typedef enum logic {CLEAR, READY} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              ready_q, ready_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic [XLEN-1:0]   mem_q [NREGS];
   logic [XLEN-1:0]   mem_d [NREGS];
`ifdef REGFILE_PARITY_EN
   logic [NREGS-1:0]  par_q, par_d;
`endif

   // Next-state: clear engine walks the array; in READY apply writes then issue
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      mem_d     = mem_q;
`ifdef REGFILE_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         CLEAR: begin
            mem_d[clr_idx_q] = '0;
`ifdef REGFILE_PARITY_EN
            par_d[clr_idx_q] = 1'b0;
`endif
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(NREGS - 1)) begin
               state_d = READY;
               ready_d = 1'b1;
            end
         end
         READY: begin
            // Ascending loop order lets the highest write port win
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                  mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
                  busy_d[wr_addr[j*AW +: AW]] = 1'b0;
`ifdef REGFILE_PARITY_EN
                  par_d[wr_addr[j*AW +: AW]]  = ^wr_data[j*XLEN +: XLEN];
`endif
               end
            end
            // Issue after writes: a new producer keeps the register busy
            if (iss_en && (iss_rd != '0)) begin
               busy_d[iss_rd] = 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
      busy_d[0] = 1'b0;
   end

   // State registers; the data array is zeroed by the clear engine, not by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         mem_q     <= mem_d;
`ifdef REGFILE_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign ready = ready_q;

   logic [NUM_RD-1:0] perr_c;

   // Read ports with write-through forwarding and busy/parity qualification
   always_comb begin
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] fwd;
      rs_data = '0;
      rs_busy = '0;
      perr_c  = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra  = rs_addr[i*AW +: AW];
         hit = 1'b0;
         fwd = '0;
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == ra) && (ra != '0)) begin
               hit = 1'b1;
               fwd = wr_data[j*XLEN +: XLEN];
            end
         end
         if ((state_q == READY) && rs_valid[i] && (ra != '0)) begin
            rs_data[i*XLEN +: XLEN] = hit ? fwd : mem_q[ra];
            rs_busy[i]              = busy_q[ra] & ~hit;
`ifdef REGFILE_PARITY_EN
            perr_c[i]               = ~hit & (par_q[ra] ^ (^mem_q[ra]));
`endif
         end
      end
   end

`ifdef REGFILE_PARITY_EN
   assign par_err = perr_c;
`else
   assign par_err = '0;
`endif

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next core generation.
- Configurable data width, register count, read-port count and write-port count.
- Per-port write-through forwarding; x0 hardwired to zero.
- Adds a scoreboard of pending writes (busy bits) for hazard detection in decode.
- Adds a sequential clear engine so reset does not require a single-cycle clear of every entry.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of two, >=2
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rs_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW]
rs_valid  in  NUM_RD  per-port read enable
rs_data  out  NUM_RD*XLEN  read data; combinational
rs_busy  out  NUM_RD  per-port: source register has a pending write not satisfied this cycle
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
iss_en  in  1  issue: mark iss_rd as pending
iss_rd  in  AW  destination register of issued instruction
ready  out  1  registered; high once the clear engine has finished
par_err  out  NUM_RD  parity error per read port (see Optional Feature)

Behaviour:
Clear engine, states CLEAR and READY:
- rst=1: state<=CLEAR, clr_idx<=0, all busy bits<=0, ready<=0.
- CLEAR, per edge with rst=0:
  - reg[clr_idx]<=0 and clr_idx<=clr_idx+1.
  - On clr_idx==NREGS-1, state<=READY and ready<=1.
  - ready therefore rises after exactly NREGS edges following rst deassertion.
- Reset mid-clear restarts from index 0.
- While in CLEAR:
  - wr_en and iss_en are ignored.
  - rs_data is all zero, rs_busy=0, par_err=0.
- READY is held until the next rst.

Reads (READY), for each port i:
- rs_valid[i]=0 or rs_addr==0: data=0.
- Otherwise, if any write port j has wr_en[j] and wr_addr[j]==rs_addr[i] and wr_addr[j]!=0: data=wr_data[j]. If several ports match, the highest index j wins.
- Otherwise: data=reg[rs_addr[i]].

Writes (READY):
- Each enabled port with wr_addr!=0 updates its register on the edge.
- Two ports writing the same address: the highest index wins.
- Writes to x0 are discarded; reg[0] always reads zero.

Scoreboard (READY):
- busy[k] is set on an edge with iss_en=1 and iss_rd==k, k!=0.
- busy[k] is cleared on an edge when any enabled write port targets k.
- Issue and write to the same k on the same edge: the issue wins, busy stays 1 (new producer).
- iss_rd==0 is ignored; busy[0] is constant 0.
- rs_busy[i] = rs_valid[i] & busy[rs_addr[i]] & ~(a forwarding write to rs_addr[i] this cycle).

General:
- No read latency.
- Write-to-read visibility is the same cycle via forwarding and the next cycle via storage.

Optional Feature:
Macro REGFILE_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit, written together with the data, including by the clear engine (parity 0 for zero data).
  - par_err[i]=1 when rs_valid[i]=1, rs_addr[i]!=0, the value comes from storage (not forwarded), and the stored parity mismatches the XOR of the stored data.
  - The data is still returned unchanged.
- Not defined: no parity storage; par_err is tied to 0.

Test Plan:
- Reset/clear, NREGS=32: pulse rst, preload via writes before reset -> ready low for 32 edges after rst falls, then high; every register reads 0.
- Forwarding, NUM_WR=2: same cycle wr_en=2'b11, both wr_addr=5, wr_data={32'hBBBB,32'hAAAA}, rs_addr[0]=5 -> rs_data[0]=32'hBBBB that cycle; reg5=32'hBBBB next cycle.
- x0: write 32'hDEADBEEF to addr 0, issue iss_rd=0 -> reads of x0 return 0; rs_busy stays 0.
- Scoreboard: iss_en with iss_rd=7 -> next cycle rs_busy=1 for rs_addr=7.
  - Write 7 with 32'h1234 -> rs_busy=0 in the write cycle (forwarded) and afterwards.
  - Simultaneous issue and write to 7 -> busy stays 1.
- Reset mid-clear: assert rst when clr_idx=10 -> clear restarts; ready rises 32 edges after the second rst falls; writes issued during CLEAR have no effect.
- REGFILE_PARITY_EN: write 32'h0000_0001 to reg 3, flip stored bit 0 via hierarchical deposit -> read of 3 gives 32'h0, par_err[i]=1.
  - Read of 3 with a concurrent forwarding write -> par_err=0.
